// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide controller.
// Op codes, FSM states and the divide-by-zero LO pattern.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_LAUNCH,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_FIXUP
    } state_e;

    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] mag(input logic [31:0] v,
                                        input logic s);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core-side op bus plus external multiplier engine handshake.
// slave = controller view, master = core/engine view.
interface muldiv_if;

    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic [31:0] rd_data;
    logic        busy;
    logic        eng_start;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        eng_busy;
    logic [31:0] eng_hi;
    logic [31:0] eng_lo;

    modport slave (
        input  op_valid, op, rs_data, rt_data,
        input  eng_busy, eng_hi, eng_lo,
        output stall, rd_data, busy,
        output eng_start, eng_a, eng_b
    );

    modport master (
        output op_valid, op, rs_data, rt_data,
        output eng_busy, eng_hi, eng_lo,
        input  stall, rd_data, busy,
        input  eng_start, eng_a, eng_b
    );

endinterface

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// o_done is high during the final step; results settle at that edge.
module muldiv_divider #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_run;

    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic        w_last;

    // shifted remainder is always < 2*divisor, so the low 32 bits
    // of the difference are exact whenever no borrow occurs
    assign w_shift = {r_rem, r_quot[31]};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    assign w_sub   = w_shift[31:0] - r_dvs;
    assign w_last  = r_cnt == 6'(DIV_STEPS - 1);

    assign o_done = r_run & w_last;
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dvs  <= i_divisor;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_rem  <= w_ge ? w_sub : w_shift[31:0];
            r_quot <= {r_quot[30:0], w_ge};
            r_cnt  <= r_cnt + 6'd1;
            if (w_last)
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO owner: sequences MULT/DIV/MTxx/MFxx, drives the external
// multiplier engine and the internal divider, applies sign fix-up.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [31:0] r_eng_a;
    logic [31:0] r_eng_b;
    logic        r_neg;
    logic        r_qneg;
    logic        r_rneg;
    logic        r_is_div;

    logic        w_idle;
    logic        w_acc;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_mthi;
    logic        w_is_mtlo;
    logic        w_signed;
    logic        w_sgn_x;
    logic        w_dz;
    logic        w_div_start;
    logic        w_div_done;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_idle    = r_state == S_IDLE;
    assign w_acc     = bus.op_valid & w_idle;
    assign w_is_mul  = bus.op == OP_MULT || bus.op == OP_MULTU;
    assign w_is_div  = bus.op == OP_DIV  || bus.op == OP_DIVU;
    assign w_is_mthi = bus.op == OP_MTHI;
    assign w_is_mtlo = bus.op == OP_MTLO;
    assign w_signed  = bus.op == OP_MULT || bus.op == OP_DIV;
    assign w_sgn_x   = w_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
    assign w_dz      = bus.rt_data == 32'd0;

    assign w_div_start = w_acc & w_is_div & ~w_dz;

    muldiv_divider #(.DIV_STEPS(DIV_STEPS)) u_div (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_start    (w_div_start),
        .i_dividend (mag(bus.rs_data, w_signed)),
        .i_divisor  (mag(bus.rt_data, w_signed)),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    assign w_prod_fix = r_neg  ? (~r_prod + 64'd1) : r_prod;
    assign w_quot_fix = r_qneg ? (~w_quot + 32'd1) : w_quot;
    assign w_rem_fix  = r_rneg ? (~w_rem  + 32'd1) : w_rem;

    assign bus.stall     = bus.op_valid & ~w_idle;
    assign bus.busy      = ~w_idle;
    assign bus.eng_start = r_state == S_MUL_LAUNCH;
    assign bus.eng_a     = r_eng_a;
    assign bus.eng_b     = r_eng_b;
    assign bus.rd_data   = (bus.op == OP_MFHI) ? r_hi :
                           (bus.op == OP_MFLO) ? r_lo : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    unique case (1'b1)
                        w_is_mul: w_next = S_MUL_LAUNCH;
                        w_is_div: w_next = w_dz ? S_FIXUP : S_DIV_RUN;
                        default:  w_next = S_IDLE;
                    endcase
                end
            end
            S_MUL_LAUNCH: w_next = S_MUL_WAIT;
            S_MUL_WAIT:   if (!bus.eng_busy) w_next = S_FIXUP;
            S_DIV_RUN:    if (w_div_done) w_next = S_FIXUP;
            S_FIXUP:      w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // divide-by-zero rides the multiply fix-up path with a preset product
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_prod   <= '0;
            r_eng_a  <= '0;
            r_eng_b  <= '0;
            r_neg    <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        unique case (1'b1)
                            w_is_mthi: r_hi <= bus.rs_data;
                            w_is_mtlo: r_lo <= bus.rs_data;
                            w_is_mul: begin
                                r_neg    <= w_sgn_x;
                                r_is_div <= 1'b0;
                                r_eng_a  <= mag(bus.rs_data, w_signed);
                                r_eng_b  <= mag(bus.rt_data, w_signed);
                            end
                            w_is_div: begin
                                r_neg    <= 1'b0;
                                r_is_div <= ~w_dz;
                                r_qneg   <= w_sgn_x;
                                r_rneg   <= w_signed & bus.rs_data[31];
                                r_prod   <= {bus.rs_data, DIV_BY_ZERO_LO};
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL_WAIT: begin
                    if (!bus.eng_busy)
                        r_prod <= {bus.eng_hi, bus.eng_lo};
                end
                S_FIXUP: begin
                    if (r_is_div)
                        {r_hi, r_lo} <= {w_rem_fix, w_quot_fix};
                    else
                        {r_hi, r_lo} <= w_prod_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller with an iterative engine model
// and a queue scoreboard checking every accepted MFHI/MFLO.
module tb_muldiv_controller;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv_controller #(.DIV_STEPS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // engine model: busy for 33 cycles after the start pulse
    int e_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.eng_busy <= 1'b0;
            bus.eng_hi   <= '0;
            bus.eng_lo   <= '0;
            e_cnt        <= 0;
        end else if (bus.eng_start) begin
            bus.eng_busy <= 1'b1;
            e_cnt        <= 32;
            {bus.eng_hi, bus.eng_lo} <=
                {32'd0, bus.eng_a} * {32'd0, bus.eng_b};
        end else if (bus.eng_busy) begin
            if (e_cnt == 0)
                bus.eng_busy <= 1'b0;
            else
                e_cnt <= e_cnt - 1;
        end
    end

    always @(posedge clk)
        if (bus.eng_start) n_start++;

    always @(negedge clk) begin
        if (bus.op_valid && !bus.stall &&
            (bus.op == OP_MFHI || bus.op == OP_MFLO)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got %h expected none",
                         bus.rd_data);
            end else begin
                check("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int st);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.rs_data  = a;
        bus.rt_data  = b;
        st = 0;
        @(negedge clk);
        while (bus.stall && st < 500) begin
            st++;
            @(negedge clk);
        end
        if (st >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_timeout: got %0d expected <500", st);
        end
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
    endtask

    task automatic rd(input logic [3:0] o, input logic [31:0] e,
                      output int st);
        exp_q.push_back(e);
        issue(o, 32'd0, 32'd0, st);
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int st;
        int nb;
        int s0;
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        bus.rs_data  = '0;
        bus.rt_data  = '0;

        #12;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_eng_start", 32'(bus.eng_start), 0);
        check("rst_eng_a", bus.eng_a, 0);
        bus.op = OP_MFHI;
        #1 check("rst_hi", bus.rd_data, 0);
        bus.op = OP_NONE;
        @(negedge clk) reset_n = 1'b1;

        issue(OP_MTHI, 32'h1234_5678, 0, st);
        check("mthi_stall", 32'(st), 0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 0, st);
        check("mtlo_stall", 32'(st), 0);
        rd(OP_MFHI, 32'h1234_5678, st);
        check("mfhi_stall", 32'(st), 0);
        rd(OP_MFLO, 32'h9ABC_DEF0, st);

        s0 = n_start;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, st);
        rd(OP_MFHI, 32'hFFFF_FFFF, st);
        check("mult_stalled", 32'(st >= 33), 1);
        check("mult_pulses", 32'(n_start - s0), 1);
        check("mult_eng_a", bus.eng_a, 32'd3);
        check("mult_eng_b", bus.eng_b, 32'd7);
        rd(OP_MFLO, 32'hFFFF_FFEB, st);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
        rd(OP_MFHI, 32'hFFFF_FFFE, st);
        rd(OP_MFLO, 32'h0000_0001, st);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, st);
        busy_cycles(nb);
        check("div_busy", 32'(nb), 33);
        rd(OP_MFLO, 32'hFFFF_FFFD, st);
        rd(OP_MFHI, 32'hFFFF_FFFF, st);

        issue(OP_DIVU, 32'd100, 32'd7, st);
        rd(OP_MFLO, 32'd14, st);
        rd(OP_MFHI, 32'd2, st);

        issue(OP_DIV, 32'h55, 32'd0, st);
        busy_cycles(nb);
        check("dz_busy", 32'(nb), 1);
        rd(OP_MFHI, 32'h55, st);
        rd(OP_MFLO, 32'hFFFF_FFFF, st);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
        rd(OP_MFLO, 32'h8000_0000, st);
        rd(OP_MFHI, 32'h0, st);

        issue(OP_DIVU, 32'd100, 32'd7, st);
        issue(OP_MULTU, 32'd3, 32'd5, st);
        check("b2b_stalled", 32'(st > 0), 1);
        rd(OP_MFLO, 32'd15, st);
        rd(OP_MFHI, 32'd0, st);

        issue(4'hF, 32'd1, 32'd1, st);
        check("undef_stall", 32'(st), 0);
        rd(OP_MFLO, 32'd15, st);

        issue(OP_DIV, 32'd1000, 32'd3, st);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1 check("rst_mid_busy", 32'(bus.busy), 0);
        bus.op = OP_MFLO;
        #1 check("rst_mid_lo", bus.rd_data, 0);
        bus.op = OP_MFHI;
        #1 check("rst_mid_hi", bus.rd_data, 0);
        bus.op = OP_NONE;
        @(negedge clk) reset_n = 1'b1;
        rd(OP_MFLO, 32'd0, st);
        check("post_rst_stall", 32'(st), 0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
- Owns the architectural HI/LO registers and sequences all MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations for the MIPS core.
- Drives the external unsigned iterative multiplier engine through a start/busy handshake and applies the sign fix-up for signed multiplies.
- Contains a 32-step restoring divider.
- Multiply and divide run in the background. The core stalls only when it issues a HI/LO-related op while an operation is still in flight.

Parameters:
- DIV_STEPS, 32, divider iterations (fixed for 32-bit; parameterised only for test shortening).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  decode presents a HI/LO-class op this cycle.
- op  in  4  op code, encoding from muldiv_pkg.
- rs_data  in  32  operand A (multiplicand, dividend, or MTxx source).
- rt_data  in  32  operand B (multiplier or divisor).
- stall  out  1  op not accepted this cycle; core holds op/op_valid/operands stable.
- rd_data  out  32  HI or LO for MFHI/MFLO; valid when op_valid & !stall.
- busy  out  1  multiply or divide in flight (state != IDLE).
- eng_start  out  1  one-cycle start pulse to the multiplier engine.
- eng_a  out  32  engine multiplicand (magnitude).
- eng_b  out  32  engine multiplier (magnitude).
- eng_busy  in  1  engine busy; rises the cycle after eng_start.
- eng_hi  in  32  engine product high word; valid when eng_busy has fallen.
- eng_lo  in  32  engine product low word; valid when eng_busy has fallen.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; HI=LO=0; eng_start=0; eng_a=eng_b=0; busy=0; divider registers=0.
  - An in-flight operation is abandoned; HI/LO are not written.
- States: IDLE, MUL_LAUNCH, MUL_WAIT, DIV_RUN, FIXUP.
- stall = op_valid & (state != IDLE). Nothing is accepted outside IDLE. No stall in IDLE for any op.
- rd_data: combinational; HI for MFHI, LO for MFLO, otherwise 0.
- MTHI/MTLO accepted in IDLE: HI/LO <= rs_data at that edge; 1 cycle.
- MULT/MULTU accepted in IDLE (edge E0):
  - Latch neg = signed & (rs[31]^rt[31]).
  - eng_a/eng_b <= |rs|/|rt| for MULT; raw values for MULTU.
  - state -> MUL_LAUNCH.
- MUL_LAUNCH: eng_start=1 for exactly this cycle; eng_busy is ignored; next -> MUL_WAIT.
- MUL_WAIT: stay while eng_busy=1. When eng_busy=0, capture {eng_hi,eng_lo} into a 64-bit product register and go to FIXUP.
- FIXUP: 1 cycle.
  - Multiply: {HI,LO} <= neg ? -{prod} (64-bit two's complement) : prod.
  - Divide: LO <= qneg ? -quot : quot; HI <= rneg ? -rem : rem.
  - Next -> IDLE. An MFHI/MFLO presented in the following IDLE cycle sees the new value.
- DIV/DIVU accepted in IDLE (E0):
  - Latch magnitudes (DIV) or raw values (DIVU).
  - qneg = signed & (rs[31]^rt[31]); rneg = signed & rs[31].
  - count=0; state -> DIV_RUN.
- DIV_RUN: one restoring step per cycle.
  - Shift {rem,quot} left; 33-bit trial subtract of the divisor; set quotient bit if no borrow.
  - After DIV_STEPS steps (edges E1..E32) -> FIXUP. HI/LO are written at E33.
- Divide by zero (rt=0) at accept: state -> FIXUP directly; writes HI=rs_data, LO=32'hFFFF_FFFF; no iteration.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0 (natural magnitude result, no special case).
- Back-to-back: a second MULT/DIV issued while busy is stalled until IDLE, then accepted that cycle.
- op_valid with op=NONE or an undefined code: ignored, no stall.
- Reset asserted mid-DIV_RUN or mid-MUL_WAIT: immediate IDLE; a later eng_busy fall is ignored.

Decomposition:
- muldiv_pkg:
  - op enum NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - state enum.
  - DIV_BY_ZERO_LO constant.
- Sub-module muldiv_divider:
  - Restoring iteration datapath plus step counter.
  - Interface: start, dividend/divisor magnitudes, done, quot, rem.
- Controller keeps the FSM, sign logic, engine handshake and HI/LO.

Test Plan:
- MTHI 0x1234_5678, MTLO 0x9ABC_DEF0, then MFHI/MFLO -> rd_data 0x1234_5678 / 0x9ABC_DEF0, stall never asserted.
- MULT rs=-3 (0xFFFF_FFFD), rt=7, engine model 33-cycle busy -> eng_a=3, eng_b=7, one eng_start pulse; MFHI stalls until FIXUP; HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV rs=-7, rt=2 -> busy 33 cycles after accept; LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100/7 -> LO=14, HI=2.
- DIV by zero rs=0x55, rt=0 -> busy 1 cycle; HI=0x55, LO=0xFFFF_FFFF. DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
- Start DIV, assert reset_n=0 at step 10 -> busy=0, HI=LO=0 immediately. After release, MFLO returns 0 with no stall.
